ascon_perm_ctrl: RTL and testbench

Sequencer and arbiter for the shared Ascon-128 permutation datapath. It accepts permutation requests from two requesters: requester 0 is the init/final path and requester 1 is the associated-data/plaintext path. It grants the datapath round-robin and drives the per-cycle round-enable and round constant for p^a (12 rounds) or p^b (6 rounds). When the last round completes, it returns a one-cycle done pulse to the owning requester.

---
 rtl/ascon_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 13 +
 rtl/ascon_perm_ctrl.sv | 81 ++++++++
 tb/tb_ascon_perm_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared Ascon definitions: round counts, permutation FSM states, round constants
// and the datapath widths used on the core's data ports.
package ascon_pkg;
  localparam int ROUNDS_A_DEF = 12;
  localparam int ROUNDS_B_DEF = 6;

  localparam int STATE_W = 320;
  localparam int LANE_W  = 64;
  localparam int RATE_W  = 64;
  localparam int KEY_W   = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Ascon round constant: upper nibble counts down from 15 while the lower counts up.
  function automatic logic [7:0] rc(input logic [3:0] idx);
    return {4'(4'd15 - idx), idx};
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: on a tie the requester that did not win last time gets it.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       accept,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_idx
);
  always_comb begin
    grant_idx = (req == 2'b11) ? ~last_grant : req[1];
    grant     = accept ? (2'b01 << grant_idx) : 2'b00;
  end
endmodule

// File: rtl/ascon_perm_ctrl.sv
// Sequencer/arbiter for the shared Ascon permutation: grants one of two requesters,
// then steps p^a or p^b rounds and returns a done pulse to the owner.
module ascon_perm_ctrl
  import ascon_pkg::*;
#(
  parameter int ROUNDS_A = ROUNDS_A_DEF,
  parameter int ROUNDS_B = ROUNDS_B_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_rounds_b,
  output logic [1:0] req_ready,
  output logic       perm_load,
  output logic       perm_sel,
  output logic       perm_round_en,
  output logic [7:0] perm_rc,
  output logic [1:0] done,
  output logic       busy
);
  // p^b runs the tail of the p^a schedule, so it simply starts further along.
  localparam logic [3:0] IDX_LAST    = 4'(ROUNDS_A - 1);
  localparam logic [3:0] IDX_START_B = 4'(ROUNDS_A - ROUNDS_B);

  state_e     state_q, state_d;
  logic [3:0] idx_q;
  logic       sel_q;
  logic       last_grant_q;
  logic       accept;
  logic       win;

  // Gated by rst so req_ready stays low while reset is held.
  assign accept = (state_q == IDLE) && (|req_valid) && !rst;

  rr_arb2 u_arb (
    .req        (req_valid),
    .accept     (accept),
    .last_grant (last_grant_q),
    .grant      (req_ready),
    .grant_idx  (win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= 4'd0;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      idx_q        <= req_rounds_b[win] ? IDX_START_B : 4'd0;
      sel_q        <= win;
      last_grant_q <= win;
    end else if (state_q == ROUND && idx_q != IDX_LAST) begin
      idx_q <= idx_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = ROUND;
      ROUND:   if (idx_q == IDX_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    perm_load     = (state_q == LOAD);
    perm_round_en = (state_q == ROUND);
    perm_rc       = perm_round_en ? rc(idx_q) : 8'h00;
    done          = (state_q == DONE) ? (2'b01 << sel_q) : 2'b00;
    busy          = (state_q != IDLE);
    perm_sel      = sel_q;
  end
endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Bench for ascon_perm_ctrl: directed scenarios then random traffic, checked against
// a schedule model (offset from accept cycle -> expected outputs).
module tb_ascon_perm_ctrl;
  localparam int RA = 12;
  localparam int RB = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, req_rounds_b, req_ready, done;
  logic       perm_load, perm_sel, perm_round_en, busy;
  logic [7:0] perm_rc;

  ascon_perm_ctrl #(.ROUNDS_A(RA), .ROUNDS_B(RB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rounds_b(req_rounds_b),
    .req_ready(req_ready), .perm_load(perm_load), .perm_sel(perm_sel),
    .perm_round_en(perm_round_en), .perm_rc(perm_rc), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rc_tbl [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                              8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

  // Reference model state: when the current operation was accepted and by whom.
  bit   have_op;
  int   t_acc, cyc, m_sel, m_n, m_last;
  bit [1:0] hold, hold_rb;
  bit   persist;
  int   acc_cyc[$];
  int   acc_who[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One cycle: drive at negedge, check #1 later, then commit model at posedge.
  task automatic step(input bit r);
    int k, win;
    bit act;
    logic [1:0] e_ready, e_done;
    logic [7:0] e_rc;
    logic e_load, e_ren;
    rst = r; req_valid = hold; req_rounds_b = hold_rb;
    if (r) begin have_op = 0; m_last = 1; m_sel = 0; end
    #1;
    k   = cyc - t_acc;
    act = have_op && k >= 1 && k <= m_n + 2;
    e_ready = 2'b00; win = 0;
    if (!r && !act && hold != 2'b00) begin
      win = (hold == 2'b11) ? 1 - m_last : (hold[1] ? 1 : 0);
      e_ready = 2'(1 << win);
    end
    e_load = act && k == 1;
    e_ren  = act && k >= 2 && k <= m_n + 1;
    e_rc   = e_ren ? rc_tbl[RA - m_n + k - 2] : 8'h00;
    e_done = (act && k == m_n + 2) ? 2'(1 << m_sel) : 2'b00;
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("perm_load", 32'(perm_load), 32'(e_load));
    chk("round_en", 32'(perm_round_en), 32'(e_ren));
    chk("perm_rc", 32'(perm_rc), 32'(e_rc));
    chk("done", 32'(done), 32'(e_done));
    chk("busy", 32'(busy), 32'(act));
    chk("perm_sel", 32'(perm_sel), 32'(m_sel));
    @(posedge clk);
    if (e_ready != 2'b00) begin
      have_op = 1; t_acc = cyc; m_sel = win; m_last = win;
      m_n = hold_rb[win] ? RB : RA;
      acc_cyc.push_back(cyc); acc_who.push_back(win);
      hold[win] = 1'b0;
    end
    cyc++;
    if (persist) hold = 2'b11;
    @(negedge clk);
  endtask

  // Structural invariants every cycle.
  always @(negedge clk) begin
    #2;
    n_cmp++;
    assert ($onehot0(req_ready) && $onehot0(done)) else begin
      n_err++; $error("FAIL onehot0: observed ready=%b done=%b expected at most one bit", req_ready, done);
    end
    n_cmp++;
    assert (perm_round_en || perm_rc == 8'h00) else begin
      n_err++; $error("FAIL rc_idle: observed %0h expected 0", perm_rc);
    end
  end

  initial begin
    cyc = 0; have_op = 0; m_last = 1; m_sel = 0; m_n = RA; t_acc = 0;
    hold = 0; hold_rb = 0; persist = 0;
    rst = 1; req_valid = 0; req_rounds_b = 0;
    @(negedge clk);
    hold = 2'b01;                      // request during reset must not be granted
    repeat (3) step(1);
    hold = 2'b00;

    // p^a on requester 0, then p^b on requester 1
    hold = 2'b01; hold_rb = 2'b00; repeat (17) step(0);
    hold = 2'b10; hold_rb = 2'b10; repeat (11) step(0);

    // both requesters holding p^b continuously
    acc_cyc.delete(); acc_who.delete();
    persist = 1; hold = 2'b11; hold_rb = 2'b11;
    repeat (40) step(0);
    persist = 0; hold = 2'b00;
    repeat (10) step(0);
    chk("alt_count", 32'(acc_who.size() >= 4), 32'd1);
    for (int i = 0; i < acc_who.size(); i++) begin
      chk("alt_order", 32'(acc_who[i]), 32'(i % 2));
      if (i > 0) chk("alt_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd9);
    end

    // requester 0 asks while requester 1 owns a p^a
    acc_cyc.delete(); acc_who.delete();
    hold = 2'b10; hold_rb = 2'b00;
    repeat (3) step(0);
    hold[0] = 1'b1; hold_rb[0] = 1'b0;
    repeat (30) step(0);
    chk("busy_req_n", 32'(acc_who.size()), 32'd2);
    if (acc_who.size() == 2) begin
      chk("busy_req_who", 32'(acc_who[1]), 32'd0);
      chk("busy_req_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'(RA + 3));
    end

    // reset during the 5th round of a p^a, then a tie goes to requester 0
    acc_cyc.delete(); acc_who.delete();
    hold = 2'b01; hold_rb = 2'b00;
    step(0);
    repeat (5) step(0);
    chk("pre_rst_round", 32'(perm_round_en), 32'd1);
    step(1);
    step(1);
    hold = 2'b11; hold_rb = 2'b11;
    repeat (12) step(0);
    chk("rst_tie_n", 32'(acc_who.size() >= 2), 32'd1);
    if (acc_who.size() >= 2) chk("rst_tie_who", 32'(acc_who[1]), 32'd0);
    hold = 2'b00;
    repeat (10) step(0);

    // random traffic
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 2; i++)
        if (!hold[i] && $urandom_range(3) == 0) begin
          hold[i] = 1'b1; hold_rb[i] = 1'($urandom_range(1));
        end
      step($urandom_range(199) == 0);
    end
    hold = 2'b00;
    repeat (20) step(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
